crc32_frame_arbiter: RTL
========================

# crc32_frame_arbiter

Frame-level controller that shares one `crc32` combinational step (CRC-32/MPEG-2, 32-bit word per step) between two streaming requesters. It grants the engine to one requester for a whole frame using round-robin arbitration. It holds the running CRC in a register, feeding it back as `init` once per accepted word. At frame end it presents the final CRC, word count and requester ID on a valid/ready result port.

## Interface
Parameters:
- `INIT` — 32'hFFFFFFFF — CRC register value loaded at frame start.
- `FINAL_XOR` — 32'h00000000 — XOR applied to the CRC when it is presented on `res_crc`.

Ports:
- `clk` in 1 — single clock; all logic on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `s0_valid` in 1 — requester 0 word valid.
- `s0_ready` out 1 — requester 0 word accepted when high together with `s0_valid`.
- `s0_data` in 32 — requester 0 word; feeds `crc32.data_in` directly.
- `s0_last` in 1 — marks the final word of the requester 0 frame.
- `s1_valid`, `s1_ready`, `s1_data`, `s1_last` — same as the requester 0 ports, for requester 1.
- `res_valid` out 1 — result available.
- `res_ready` in 1 — result consumed when high together with `res_valid`.
- `res_crc` out 32 — final CRC XOR `FINAL_XOR`.
- `res_len` out 16 — number of words in the frame; saturates at 16'hFFFF.
- `res_id` out 1 — requester that owned the frame.

## Operation
- The block instantiates one `crc32`. Its `init` input is the CRC register and its `data_in` input is the granted channel's data. `crc_out` is the next-state value.
- FSM states: IDLE, BUSY, DONE. Reset sends the FSM to IDLE.
- IDLE:
  - `s0_ready`, `s1_ready` and `res_valid` are 0.
  - If any `sX_valid` is high, grant one requester. If only one is valid, it gets the grant. If both are valid, the requester not granted most recently wins.
  - After reset, the priority pointer favours requester 0.
  - On a grant: latch `grant`, load the CRC register with `INIT`, load the word counter with 0, go to BUSY.
- BUSY:
  - `sX_ready` = 1 for the granted requester only; the other requester's ready stays 0.
  - On each handshake of the granted requester: CRC register <= `crc_out` and the counter increments, saturating at 16'hFFFF.
  - Valid gaps are allowed with no timeout; the CRC register and counter hold during gaps.
  - A handshake with `last`=1 captures the final word and moves the FSM to DONE.
  - A frame with no word carrying `last` never ends.
- DONE:
  - `res_valid` = 1; `res_crc`, `res_len` and `res_id` are stable.
  - While `res_valid` is high and `res_ready` is low, the result holds.
  - On a `res_valid`/`res_ready` handshake, go to IDLE and set the priority pointer to favour the requester not just served.
- The `last` signal of the non-granted requester is ignored. Its data is never consumed.
- Reset mid-frame:
  - All state clears immediately; the partial frame is discarded and no result is emitted.
  - Requesters must restart their frames.

## Timing
- Reset values: `s0_ready` = `s1_ready` = 0, `res_valid` = 0, `res_crc` = 0, `res_len` = 0, `res_id` = 0. The priority pointer favours requester 0.
- Grant latency: `sX_valid` seen in IDLE at cycle t → `sX_ready` is high from cycle t+1. The requester's word stays pending until accepted.
- Throughput: 1 word/cycle while BUSY and the granted requester's valid is high.
- Result latency: handshake on the last word in cycle N → `res_valid` is high in cycle N+1.
- Back-to-back frames: the earliest next grant is the cycle after the result handshake. Minimum gap between frames is 2 cycles (DONE → IDLE → BUSY).
- All outputs are driven directly from registers or FSM state. No combinational path exists from an `sX_valid` input to `sX_ready`, or from `res_ready` to any output.

## Test plan
- Single word, both parameters at default:
  - s0 sends {32'hFFFFFFFF, last} → `res_crc` = 32'h00000000, `res_len` = 1, `res_id` = 0, `res_valid` high 1 cycle after acceptance.
- Two-word frame on s1:
  - s1 sends {32'hFFFFFFFF, 32'h00000000 last} → `res_crc` = 32'h00000000, `res_len` = 2, `res_id` = 1.
  - `s0_ready` stays 0 throughout.
- Contention:
  - Both valid from the cycle after reset, each with a 3-word random frame, repeated 4 times → grants alternate 0, 1, 0, 1.
  - Every CRC matches a bit-serial MPEG-2 model (poly 0x04C11DB7, MSB-first, init 0xFFFFFFFF).
- Backpressure:
  - Hold `res_ready` = 0 for 10 cycles after `res_valid` rises → result fields stable.
  - `s0_ready` and `s1_ready` stay 0 and no new grant occurs.
- Valid gaps:
  - A 5-word random frame with idle cycles inserted between words → same `res_crc` as the gap-free frame, `res_len` = 5.
- Reset mid-frame:
  - Assert `rst_n` = 0 after 2 of 4 words → all outputs return to reset values asynchronously.
  - A fresh single-word 32'hFFFFFFFF frame then yields 32'h00000000.

Source files
------------

// File: rtl/crc32_frame_arbiter.sv
// crc32_frame_arbiter: shares one combinational CRC-32/MPEG-2 word step
// between two streaming requesters. The engine is granted for a whole frame
// with round-robin arbitration. The result is presented on a valid/ready port.

// One CRC-32/MPEG-2 step over a full 32-bit word. The input is MSB-first,
// with polynomial 0x04C11DB7 and no reflection.
module crc32 (
  input  logic [31:0] init,
  input  logic [31:0] data_in,
  output logic [31:0] crc_out
);
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic [31:0] w_crc;

  // The word is aligned with the register, so it is XORed in once.
  // The register is then shifted 32 times.
  always_comb begin
    w_crc = init ^ data_in;
    for (int i = 0; i < 32; i++) begin
      w_crc = w_crc[31] ? ({w_crc[30:0], 1'b0} ^ POLY) : {w_crc[30:0], 1'b0};
    end
  end

  assign crc_out = w_crc;
endmodule

module crc32_frame_arbiter #(
  parameter logic [31:0] INIT      = 32'hFFFFFFFF,
  parameter logic [31:0] FINAL_XOR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [31:0] s0_data,
  input  logic        s0_last,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [31:0] s1_data,
  input  logic        s1_last,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_crc,
  output logic [15:0] res_len,
  output logic        res_id
);
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_grant;      // requester owning the current frame
  logic        r_prio;       // requester favoured on the next contended grant
  logic [31:0] r_crc;
  logic [15:0] r_cnt;
  logic [31:0] r_res_crc;
  logic [15:0] r_res_len;
  logic        r_res_id;

  logic        w_sel_valid;
  logic        w_sel_last;
  logic [31:0] w_sel_data;
  logic [31:0] w_crc_next;
  logic [15:0] w_cnt_inc;
  logic        w_accept;
  logic        w_grant_go;
  logic        w_grant_id;
  logic        w_res_hs;

  // Only the granted channel is looked at. The other channel's data and last are ignored.
  assign w_sel_valid = r_grant ? s1_valid : s0_valid;
  assign w_sel_last  = r_grant ? s1_last  : s0_last;
  assign w_sel_data  = r_grant ? s1_data  : s0_data;

  assign w_accept   = (r_state == ST_BUSY) && w_sel_valid;
  assign w_grant_go = (r_state == ST_IDLE) && (s0_valid || s1_valid);
  // Under contention the pointer decides. Otherwise the lone requester wins.
  assign w_grant_id = (s0_valid && s1_valid) ? r_prio : s1_valid;
  assign w_res_hs   = (r_state == ST_DONE) && res_ready;
  assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

  crc32 u_crc (
    .init    (r_crc),
    .data_in (w_sel_data),
    .crc_out (w_crc_next)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic. A frame ends only on an accepted word carrying last.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_grant_go)              w_state_next = ST_BUSY;
      ST_BUSY: if (w_accept && w_sel_last)  w_state_next = ST_DONE;
      ST_DONE: if (w_res_hs)                w_state_next = ST_IDLE;
      default:                              w_state_next = ST_IDLE;
    endcase
  end

  // Latch the grant on frame start. Rotate priority away from the requester just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      if (w_grant_go) r_grant <= w_grant_id;
      if (w_res_hs)   r_prio  <= ~r_grant;
    end
  end

  // Running CRC and word count. Both hold through valid gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 32'h0;
      r_cnt <= 16'h0;
    end else if (w_grant_go) begin
      r_crc <= INIT;
      r_cnt <= 16'h0;
    end else if (w_accept) begin
      r_crc <= w_crc_next;
      r_cnt <= w_cnt_inc;
    end
  end

  // Capture the result together with the last word. It stays stable throughout DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_crc <= 32'h0;
      r_res_len <= 16'h0;
      r_res_id  <= 1'b0;
    end else if (w_accept && w_sel_last) begin
      r_res_crc <= w_crc_next ^ FINAL_XOR;
      r_res_len <= w_cnt_inc;
      r_res_id  <= r_grant;
    end
  end

  assign s0_ready  = (r_state == ST_BUSY) && !r_grant;
  assign s1_ready  = (r_state == ST_BUSY) &&  r_grant;
  assign res_valid = (r_state == ST_DONE);
  assign res_crc   = r_res_crc;
  assign res_len   = r_res_len;
  assign res_id    = r_res_id;
endmodule
